// File: rtl/snake_food_sched_pkg.sv
// Shared types and constants for the snake food-placement scheduler.
package snake_pkg;
   localparam int IDX_W = 6;
   localparam int TRY_W = 7;
   localparam int N_OCC = 5;

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [TRY_W-1:0] try_t;

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [3:0] SEED_A_DEF = 4'b1001;
   localparam logic [3:0] SEED_B_DEF = 4'b0110;

   // x^4 + x^3 + 1 style Fibonacci step, period 15 from any non-zero state.
   function automatic logic [3:0] lfsr4_next(input logic [3:0] q);
      return {q[2:0], q[3] ^ q[2]};
   endfunction
endpackage

// File: rtl/snake_food_sched_if.sv
// Request/occupancy inputs and food result outputs of the scheduler.
interface snake_food_sched_if;
   import snake_pkg::*;

   logic req;
   idx_t idx_head_next;
   idx_t idx_head_now;
   idx_t idx0_now;
   idx_t idx1_now;
   idx_t idx2_now;
   logic busy;
   idx_t food_idx;
   logic food_valid;
   logic food_fail;

   modport master (
      output req, idx_head_next, idx_head_now, idx0_now, idx1_now, idx2_now,
      input  busy, food_idx, food_valid, food_fail
   );

   modport slave (
      input  req, idx_head_next, idx_head_now, idx0_now, idx1_now, idx2_now,
      output busy, food_idx, food_valid, food_fail
   );
endinterface

// File: rtl/snake_food_sched_lfsr4.sv
// Free-running 4-bit LFSR, reloaded with SEED on reset.
module snake_lfsr4
   import snake_pkg::*;
#(
   parameter logic [3:0] SEED = 4'b0001
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] q
);
   always_ff @(posedge clk) begin
      if (rst) q <= SEED;
      else     q <= lfsr4_next(q);
   end
endmodule

// File: rtl/snake_food_sched.sv
// Picks a random free board cell for new food: random start, linear probe
// upward (mod 64) past occupied cells, gives up after MAX_TRIES candidates.
module snake_food_sched
   import snake_pkg::*;
#(
   parameter int         MAX_TRIES = 64,
   parameter idx_t       FOOD_INIT = 6'd36,
   parameter logic [3:0] SEED_A    = SEED_A_DEF,
   parameter logic [3:0] SEED_B    = SEED_B_DEF
) (
   input logic               clk,
   input logic               rst,
   snake_food_sched_if.slave bus
);
   localparam try_t LAST_TRY = TRY_W'(MAX_TRIES - 1);

   logic [3:0] a_q, b_q;

   snake_lfsr4 #(.SEED(SEED_A)) u_lfsr_a (.clk(clk), .rst(rst), .q(a_q));
   snake_lfsr4 #(.SEED(SEED_B)) u_lfsr_b (.clk(clk), .rst(rst), .q(b_q));

   state_t                 state, state_nx;
   idx_t                   cand, cand_nx;
   try_t                   tr, tr_nx;
   logic [N_OCC-1:0][IDX_W-1:0] snap, snap_nx;
   idx_t                   food_q, food_nx;
   logic                   vld_q, vld_nx;
   logic                   fail_q, fail_nx;
   logic                   hit;

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < N_OCC; i++)
         if (snap[i] == cand) hit = 1'b1;
   end

   always_comb begin
      state_nx = state;
      cand_nx  = cand;
      tr_nx    = tr;
      snap_nx  = snap;
      food_nx  = food_q;
      vld_nx   = 1'b0;
      fail_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.req) begin
               snap_nx  = {bus.idx2_now, bus.idx1_now, bus.idx0_now,
                           bus.idx_head_now, bus.idx_head_next};
               cand_nx  = {a_q[2:0], b_q[2:0]};
               tr_nx    = '0;
               state_nx = SCAN;
            end
         end
         SCAN: begin
            if (!hit) begin
               food_nx  = cand;
               vld_nx   = 1'b1;
               state_nx = IDLE;
            end else if (tr == LAST_TRY) begin
               fail_nx  = 1'b1;
               state_nx = IDLE;
            end else begin
               cand_nx = cand + 6'd1;
               tr_nx   = tr + 7'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cand   <= '0;
         tr     <= '0;
         snap   <= '0;
         food_q <= FOOD_INIT;
         vld_q  <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cand   <= cand_nx;
         tr     <= tr_nx;
         snap   <= snap_nx;
         food_q <= food_nx;
         vld_q  <= vld_nx;
         fail_q <= fail_nx;
      end
   end

   assign bus.busy       = (state == SCAN);
   assign bus.food_idx   = food_q;
   assign bus.food_valid = vld_q;
   assign bus.food_fail  = fail_q;

   // A zero LFSR state would lock up the random start permanently.
   lfsr_nz: assert property (@(posedge clk) disable iff (rst)
                             (a_q != 4'd0) && (b_q != 4'd0));
endmodule

// File: doc/snake_food_sched.md
SNAKE_FOOD_SCHED -- requirements
Module: snake_food_sched

Interface
REQ-001 Parameter MAX_TRIES, default 64, maximum candidates examined per request (legal range 1..64).
REQ-002 Parameter FOOD_INIT, default 6'd36, food index held after reset.
REQ-003 Parameter SEED_A, default 4'b1001, reset value of LFSR A (must be non-zero).
REQ-004 Parameter SEED_B, default 4'b0110, reset value of LFSR B (must be non-zero).
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req  input  1  request for a new food position (food eaten / game start), sampled in IDLE only.
REQ-008 idx_head_next, idx_head_now, idx0_now, idx1_now, idx2_now  input  6 each  occupied cell indices on the 8x8 board.
REQ-009 busy  output  1  high while in SCAN.
REQ-010 food_idx  output  6  registered current food cell index.
REQ-011 food_valid  output  1  one-cycle pulse: food_idx just updated.
REQ-012 food_fail  output  1  one-cycle pulse: MAX_TRIES candidates all collided, food_idx unchanged.

Function
REQ-013 Two 4-bit LFSRs step every cycle, including during SCAN: next = {q[2:0], q[3]^q[2]}; period 15; never zero.
REQ-014 States: IDLE, SCAN; no other states reachable.
REQ-015 IDLE with req=1 at an edge: snapshot all five occupied indices, load cand = {lfsrA[2:0], lfsrB[2:0]} (values present before that edge), clear try counter, enter SCAN.
REQ-016 IDLE with req=0: hold state; food_valid, food_fail low.
REQ-017 SCAN each cycle: collision = cand equals any snapshotted index (duplicates permitted).
REQ-018 SCAN, no collision: food_idx <= cand, food_valid=1 for the next cycle, return to IDLE.
REQ-019 SCAN, collision, try < MAX_TRIES-1: cand <= cand+1 modulo 64 (63 wraps to 0), try <= try+1, stay in SCAN.
REQ-020 SCAN, collision, try == MAX_TRIES-1: food_fail=1 for the next cycle, food_idx held, return to IDLE.
REQ-021 Latency: with k collisions (k < MAX_TRIES), food_valid is high in the cycle following edge N+1+k, N = accepting edge; minimum 2 edges.
REQ-022 req while busy is ignored, not queued; snapshot inputs are not re-sampled during SCAN.
REQ-023 req asserted in the cycle food_valid/food_fail is high is accepted (back-to-back requests legal).
REQ-024 Try counter 7 bits wide; cand arithmetic 6 bits, carry discarded.
REQ-025 With 5 occupied indices and MAX_TRIES >= 6, food_fail never asserts.

Reset
REQ-026 rst=1 at an edge: state IDLE, busy=0, food_valid=0, food_fail=0, food_idx=FOOD_INIT, LFSR A=SEED_A, LFSR B=SEED_B, try=0, cand=0.
REQ-027 Reset mid-SCAN aborts the search with no pulse; reset has priority over simultaneous req.

Structure
REQ-028 Shared package snake_pkg holds the board index width (6), state enum, and default LFSR seeds.
REQ-029 One sub-module snake_lfsr4 (parameter SEED, ports clk, rst, q[3:0]), instantiated twice.
REQ-030 Collision compare is combinational inside snake_food_sched; all outputs are registered.

Verification
REQ-031 Reset then req=1 on first post-reset edge, all indices=63 -> cand 14 (6'b001110), food_valid one edge later, food_idx=14, busy high one cycle.
REQ-032 As REQ-031 with idx_head_next=14, idx_head_now=15, idx0_now=16 -> food_idx=17, food_valid after 3 extra SCAN cycles.
REQ-033 Bench advances LFSRs until cand=62, occupies 62 and 63 -> food_idx=0 (wrap-around).
REQ-034 MAX_TRIES=2, occupy 14 and 15, req as REQ-031 -> food_fail pulse, food_idx stays 36, busy drops.
REQ-035 rst asserted in 2nd SCAN cycle of REQ-032 -> no food_valid, food_idx=36, LFSRs reseeded; req during SCAN ignored; req on food_valid cycle accepted.
